// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift/truncate unit: operation select and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL    = 3'b000,
        OP_SRL    = 3'b001,
        OP_SRA    = 3'b010,
        OP_ROL    = 3'b011,
        OP_ROR    = 3'b100,
        OP_TRUNC  = 3'b101,
        OP_TRUNCS = 3'b110,
        OP_ILL    = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_trunc_seq_trunc_mask.sv
// Combinational truncate: keeps the low k bits of value, optionally sign-extending from bit k-1.
module trunc_mask #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [SHW-1:0]   k,
    input  logic             sign_ext,
    output logic [WIDTH-1:0] trunc
);

    logic [WIDTH-1:0] mask;
    logic [SHW-1:0]   top_idx;
    logic             sign;

    // k = 0 gives an empty mask, and the sign bit is forced low so both flavours return zero
    always_comb begin
        mask    = ~({WIDTH{1'b1}} << k);
        top_idx = k - SHW'(1);
        sign    = sign_ext && (k != '0) && value[top_idx];
        trunc   = (value & mask) | ({WIDTH{sign}} & ~mask);
    end

endmodule

// File: rtl/shift_trunc_seq.sv
// Sequential shift/rotate/truncate unit: shifts move at most STEP bits per cycle through one registered stage.
module shift_trunc_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [SHW-1:0]   in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

    state_e           state, state_nxt;
    op_e              op_q, op_nxt, op_in;
    logic [SHW-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic             err_q, err_nxt;
    logic [WIDTH-1:0] trunc_val;
    logic [WIDTH-1:0] shifted;
    logic [SHW:0]     s;

    assign op_in = op_e'(op);

    trunc_mask #(.WIDTH(WIDTH)) u_trunc (
        .value    (in1),
        .k        (in2),
        .sign_ext (op_in == OP_TRUNCS),
        .trunc    (trunc_val)
    );

    // One shift stage of up to STEP positions; SRA keeps the MSB, which is still the original sign bit
    always_comb begin
        s = ({1'b0, rem} > STEP_W) ? STEP_W : {1'b0, rem};
        case (op_q)
            OP_SLL:  shifted = work << s;
            OP_SRL:  shifted = work >> s;
            OP_SRA:  shifted = WIDTH'($signed(work) >>> s);
            OP_ROL:  shifted = (work << s) | (work >> (WIDTH_W - s));
            OP_ROR:  shifted = (work >> s) | (work << (WIDTH_W - s));
            default: shifted = work;
        endcase
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        rem_nxt   = rem;
        work_nxt  = work;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    op_nxt   = op_in;
                    rem_nxt  = in2;
                    work_nxt = in1;
                    err_nxt  = 1'b0;
                    case (op_in)
                        OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR:
                            state_nxt = (in2 == '0) ? ST_DONE : ST_BUSY;
                        OP_TRUNC, OP_TRUNCS: begin
                            work_nxt  = trunc_val;
                            state_nxt = ST_DONE;
                        end
                        default: begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                work_nxt = shifted;
                rem_nxt  = rem - s[SHW-1:0];
                if (rem == s[SHW-1:0])
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Flush overrides everything, including a same-edge accept or out_ready
        if (flush) begin
            state_nxt = ST_IDLE;
            op_nxt    = op_q;
            rem_nxt   = '0;
            work_nxt  = work;
            err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_SLL;
            rem   <= '0;
            work  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            rem   <= rem_nxt;
            work  <= work_nxt;
            err_q <= err_nxt;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign result    = work;
    assign zero      = (work == '0);
    assign err       = err_q;

endmodule

// File: tb/tb_shift_trunc_seq.sv
// Directed self-checking bench for shift_trunc_seq: STEP=1 and STEP=4 instances at WIDTH=32.
module tb_shift_trunc_seq;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [4:0]  in2;
    logic        in_ready, out_valid, zero, err, busy;
    logic [31:0] result;

    logic        flush4, in_valid4, out_ready4;
    logic [2:0]  op4;
    logic [31:0] in14;
    logic [4:0]  in24;
    logic        in_ready4, out_valid4, zero4, err4, busy4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;
    logic [31:0] held;

    shift_trunc_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err), .busy(busy)
    );

    shift_trunc_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op4), .in1(in14), .in2(in24), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .zero(zero4), .err(err4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [4:0] b);
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; in1 = '0; in2 = '0;
        flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; op4 = '0; in14 = '0; in24 = '0;
        $display("[TB] start");
        waitEdges(2);

        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_zero", zero, 1'b1);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        waitEdges(1);
        checkOutput("post_rst_in_ready", in_ready, 1'b1);

        // SRA by 4 with STEP=1: four edges of latency, sign fill
        applyStimulus(OP_SRA, 32'h8000_0000, 5'd4);
        checkOutput("sra_busy", busy, 1'b1);
        checkOutput("sra_in_ready", in_ready, 1'b0);
        waitEdges(3);
        checkOutput("sra_early_valid", out_valid, 1'b0);
        waitEdges(1);
        checkOutput("sra_valid", out_valid, 1'b1);
        checkOutput("sra_result", result, 32'hF800_0000);
        checkOutput("sra_zero", zero, 1'b0);
        checkOutput("sra_err", err, 1'b0);
        consume();
        checkOutput("sra_released", out_valid, 1'b0);
        checkOutput("sra_in_ready", in_ready, 1'b1);

        applyStimulus(OP_TRUNCS, 32'h0000_00F0, 5'd8);
        checkOutput("truncs_valid", out_valid, 1'b1);
        checkOutput("truncs_result", result, 32'hFFFF_FFF0);
        consume();
        applyStimulus(OP_TRUNCS, 32'hFFFF_FF70, 5'd8);
        checkOutput("truncs_pos_result", result, 32'h0000_0070);
        consume();
        applyStimulus(OP_TRUNC, 32'hDEAD_BEEF, 5'd12);
        checkOutput("trunc12_result", result, 32'h0000_0EEF);
        consume();
        applyStimulus(OP_TRUNC, 32'hDEAD_BEEF, 5'd0);
        checkOutput("trunc0_valid", out_valid, 1'b1);
        checkOutput("trunc0_result", result, 32'h0);
        checkOutput("trunc0_zero", zero, 1'b1);
        consume();
        applyStimulus(OP_TRUNCS, 32'hFFFF_FFFF, 5'd0);
        checkOutput("truncs0_result", result, 32'h0);
        consume();

        applyStimulus(OP_SRL, 32'hA5A5_A5A5, 5'd0);
        checkOutput("shift0_valid", out_valid, 1'b1);
        checkOutput("shift0_result", result, 32'hA5A5_A5A5);
        consume();

        // SLL by 3 then back-pressure for five cycles
        applyStimulus(OP_SLL, 32'h0000_0011, 5'd3);
        waitEdges(3);
        checkOutput("sll_valid", out_valid, 1'b1);
        checkOutput("sll_result", result, 32'h0000_0088);
        for (int i = 0; i < 5; i++) begin
            waitEdges(1);
            checkOutput("sll_hold_result", result, 32'h0000_0088);
            checkOutput("sll_hold_valid", out_valid, 1'b1);
            checkOutput("sll_hold_in_ready", in_ready, 1'b0);
        end
        consume();
        checkOutput("sll_idle", busy, 1'b0);
        checkOutput("sll_in_ready", in_ready, 1'b1);

        applyStimulus(OP_SRL, 32'h8000_0000, 5'd31);
        waitEdges(30);
        checkOutput("srl31_early_valid", out_valid, 1'b0);
        waitEdges(1);
        checkOutput("srl31_result", result, 32'h0000_0001);
        consume();

        // Flush two cycles into a long SRL, then immediately issue a new request
        applyStimulus(OP_SRL, 32'hFFFF_FFFF, 5'd10);
        waitEdges(1);
        flush = 1'b1;
        waitEdges(1);
        flush = 1'b0;
        checkOutput("flush_busy", busy, 1'b0);
        checkOutput("flush_out_valid", out_valid, 1'b0);
        checkOutput("flush_in_ready", in_ready, 1'b1);
        applyStimulus(OP_ROR, 32'h0000_0001, 5'd1);
        checkOutput("after_flush_accept", busy, 1'b1);
        waitEdges(1);
        checkOutput("ror_valid", out_valid, 1'b1);
        checkOutput("ror_result", result, 32'h8000_0000);
        consume();

        in_valid = 1'b1; op = OP_SLL; in1 = 32'h1; in2 = 5'd3; flush = 1'b1;
        waitEdges(1);
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_beats_accept", busy, 1'b0);

        applyStimulus(OP_ILL, 32'h1234_5678, 5'd7);
        checkOutput("ill_valid", out_valid, 1'b1);
        checkOutput("ill_result", result, 32'h1234_5678);
        checkOutput("ill_err", err, 1'b1);
        held = result;
        flush = 1'b1; out_ready = 1'b0;
        waitEdges(1);
        flush = 1'b0;
        checkOutput("flush_done_valid", out_valid, 1'b0);
        checkOutput("flush_done_err", err, 1'b0);
        checkOutput("flush_done_result_held", result, held);

        // STEP=4 instance: ROL by 5 takes two edges, SRL by 9 takes three
        in_valid4 = 1'b1; op4 = OP_ROL; in14 = 32'h8000_0001; in24 = 5'd5;
        waitEdges(1);
        in_valid4 = 1'b0;
        waitEdges(1);
        checkOutput("rol4_early_valid", out_valid4, 1'b0);
        waitEdges(1);
        checkOutput("rol4_valid", out_valid4, 1'b1);
        checkOutput("rol4_result", result4, 32'h0000_0030);
        out_ready4 = 1'b1;
        waitEdges(1);
        out_ready4 = 1'b0;
        checkOutput("rol4_released", in_ready4, 1'b1);
        in_valid4 = 1'b1; op4 = OP_SRL; in14 = 32'h8000_0000; in24 = 5'd9;
        waitEdges(1);
        in_valid4 = 1'b0;
        waitEdges(2);
        checkOutput("srl4_early_valid", out_valid4, 1'b0);
        waitEdges(1);
        checkOutput("srl4_valid", out_valid4, 1'b1);
        checkOutput("srl4_result", result4, 32'h0040_0000);
        out_ready4 = 1'b1;
        waitEdges(1);
        out_ready4 = 1'b0;

        // Asynchronous reset in the middle of a shift
        applyStimulus(OP_SLL, 32'h0000_0001, 5'd20);
        waitEdges(3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_result", result, 32'h0);
        checkOutput("midrst_zero", zero, 1'b1);
        checkOutput("midrst_err", err, 1'b0);
        waitEdges(1);
        rst_n = 1'b1;
        waitEdges(1);
        checkOutput("midrst_in_ready", in_ready, 1'b1);
        waitEdges(20);
        checkOutput("midrst_no_result", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_trunc_seq.md
SHIFT_TRUNC_SEQ -- requirements
Module: shift_trunc_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, 8..64, power of two.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per cycle, power of two, 1..WIDTH.
REQ-003 Localparam SHW = log2(WIDTH): width of the amount field.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous abort of any in-flight operation.
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-009 op  input  3  operation select: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101 TRUNC, 110 TRUNCS, 111 illegal.
REQ-010 in1  input  WIDTH  operand.
REQ-011 in2  input  SHW  shift amount, or kept-bit count k for the truncate ops.
REQ-012 out_valid  output  1  result valid; held until accepted.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  WIDTH  operation result.
REQ-015 zero  output  1  result == 0; valid while out_valid is high.
REQ-016 err  output  1  illegal op; valid while out_valid is high.
REQ-017 busy  output  1  state != IDLE.

Function
REQ-018 FSM states are IDLE, BUSY and DONE; only those three.
REQ-019 Accept occurs on an edge with in_valid & in_ready & !flush; op, in1 and in2 are captured on that edge.
REQ-020 Shift ops: on accept, rem := in2. In BUSY, each edge shifts the working register by s = min(STEP, rem) and sets rem := rem - s.
REQ-021 Latency: out_valid is first high after accept edge + ceil(in2/STEP) edges. in2 = 0 goes to DONE on the accept edge with result = in1.
REQ-022 SLL/SRL fill with zeros. SRA fills with the original in1[WIDTH-1]. ROL/ROR wrap the bits around. Amounts are taken modulo WIDTH by construction of the field width.
REQ-023 TRUNC: result = in1 with bits at index >= k cleared. TRUNCS: low k bits of in1, sign-extended from bit k-1. k = 0 gives result 0 for both ops. These ops go IDLE->DONE on the accept edge (latency 0 extra cycles).
REQ-024 Illegal op: result = in1 and err = 1; goes to DONE on the accept edge.
REQ-025 DONE -> IDLE on an edge with out_ready. result, zero and err stay stable while out_valid & !out_ready.
REQ-026 No new request is accepted in the edge where DONE is left; in_ready rises in the following cycle.
REQ-027 flush: from any state, go to IDLE on the next edge, discard the operation, drop out_valid and produce no result. flush wins over a simultaneous accept or out_ready.
REQ-028 When out_valid is low, result is don't-care to the consumer but holds its last value (no X).

Reset
REQ-029 On rst_n low, immediately: state = IDLE, rem = 0, working register = 0, out_valid = 0, err = 0, busy = 0. result reads 0 and zero reads 1.
REQ-030 in_ready goes high in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation aborts it with no result output.

Structure
REQ-032 A shared package shift_pkg holds the op encoding enum (OP_SLL..OP_ILL) and the FSM state typedef.
REQ-033 One sub-module trunc_mask (combinational: WIDTH, k, signed -> truncated value) serves TRUNC and TRUNCS.
REQ-034 Shifting uses a single registered datapath with one min(STEP, rem) stage per cycle, not a full barrel shifter.

Verification
REQ-035 WIDTH=32, STEP=1, SRA, in1=0x8000_0000, in2=4 -> out_valid 4 edges after accept, result=0xF800_0000, zero=0.
REQ-036 STEP=4, ROL, in1=0x8000_0001, in2=5 -> out_valid 2 edges after accept, result=0x0000_0030.
REQ-037 TRUNCS, in1=0x0000_00F0, in2=8 -> out_valid right after the accept edge, result=0xFFFF_FFF0. TRUNC with in2=0 -> result=0, zero=1.
REQ-038 SLL, in2=3, out_ready held low 5 cycles -> result stable and in_ready low throughout. out_ready=1 -> IDLE next edge.
REQ-039 flush asserted 2 cycles into SRL in2=10 -> IDLE next edge, no out_valid. A new request is accepted in the next cycle.
REQ-040 op=111, in1=0x1234_5678 -> result=0x1234_5678, err=1. rst_n pulsed low mid-shift -> all outputs at reset values immediately.
